// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
//  Module      : fifo_wr_arbiter_pkg
//  Description : Shared definitions for the FIFO write arbiter: arbiter state
//                encoding and the default FIFO geometry. The FIFO behind the
//                arbiter has a 3-bit buffer address, so it holds 8 entries,
//                and its occupancy counter needs 4 bits to represent "full".
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fifo_wr_arbiter_pkg;

    localparam int c_depth_default = 8;
    localparam int c_cnt_w_default = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans req starting at
//                rr_ptr and wrapping modulo NUM_REQ; reports the first set
//                index as winner and whether any request is present.
//  Ports       : req    [NUM_REQ-1:0] request vector
//                rr_ptr [ID_W-1:0]    index with highest priority (< NUM_REQ)
//                winner [ID_W-1:0]    selected requester (0 when any=0)
//                any                  at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    int              w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk offsets from the far end back to zero so the smallest offset from
    // rr_ptr is the last assignment to win.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_sum  = 0;
        w_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = int'(rr_ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = ID_W'(w_sum);
            if (req[w_idx]) begin
                winner = w_idx;
                any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin write arbiter sharing one synchronous FIFO among
//                NUM_REQ producers. A producer owns the FIFO write port for a
//                burst of up to BURST_MAX beats; writes are throttled using
//                the FIFO occupancy plus the registered write still in flight.
//  Ports       : clk, rst (async, active-high)
//                req/req_data/req_last   producer handshake inputs
//                req_ack                 combinational accept, one-hot or zero
//                fifo_counter            FIFO occupancy
//                fifo_wr_en/fifo_din     registered FIFO write port
//                gnt_valid/gnt_id        burst ownership status
//                burst_abort             one-cycle pulse on owner dropping req
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = c_depth_default,
    parameter  int CNT_W     = c_cnt_w_default,
    parameter  int BURST_MAX = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    input  logic [CNT_W-1:0]          fifo_counter,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      gnt_valid,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      burst_abort
);

    localparam int                 c_bc_w      = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W:0]     c_depth     = (CNT_W + 1)'(DEPTH);
    localparam logic [c_bc_w-1:0]  c_last_beat = c_bc_w'(BURST_MAX - 1);

    arb_state_t          r_state,     w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr,    w_rr_nxt;
    logic [ID_W-1:0]     r_owner,     w_owner_nxt;
    logic [c_bc_w-1:0]   r_beat_cnt,  w_beat_nxt;
    logic                r_wr_en,     w_wr_nxt;
    logic [DATA_W-1:0]   r_din,       w_din_nxt;
    logic                r_gnt_valid, w_gv_nxt;
    logic                r_abort,     w_abort_nxt;

    logic [NUM_REQ-1:0]  w_ack;
    logic [ID_W-1:0]     w_winner;
    logic                w_any;
    logic                w_space;
    logic [DATA_W-1:0]   w_data [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The registered write has not yet been counted by the FIFO, so it is
    // added here; CNT_W+1 bits keep DEPTH-1+1 from wrapping.
    assign w_space = ({1'b0, fifo_counter} + {{CNT_W{1'b0}}, r_wr_en}) < c_depth;

    function automatic logic [ID_W-1:0] f_wrap_inc(input logic [ID_W-1:0] id);
        if (int'(id) >= NUM_REQ - 1) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    always_comb begin
        w_ack       = '0;
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat_cnt;
        w_wr_nxt    = 1'b0;
        w_din_nxt   = r_din;
        w_gv_nxt    = r_gnt_valid;
        w_abort_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && w_space) begin
                    w_ack[w_winner] = 1'b1;
                    w_wr_nxt        = 1'b1;
                    w_din_nxt       = w_data[w_winner];
                    w_owner_nxt     = w_winner;
                    w_beat_nxt      = c_bc_w'(1);
                    // Single-beat bursts never enter OWN; rotate right away.
                    if (req_last[w_winner] || (BURST_MAX == 1)) begin
                        w_rr_nxt = f_wrap_inc(w_winner);
                    end else begin
                        w_state_nxt = ST_OWN;
                        w_gv_nxt    = 1'b1;
                    end
                end
            end
            ST_OWN: begin
                if (!req[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_gv_nxt    = 1'b0;
                    w_abort_nxt = 1'b1;
                    w_rr_nxt    = f_wrap_inc(r_owner);
                end else if (w_space) begin
                    w_ack[r_owner] = 1'b1;
                    w_wr_nxt       = 1'b1;
                    w_din_nxt      = w_data[r_owner];
                    w_beat_nxt     = r_beat_cnt + c_bc_w'(1);
                    if (req_last[r_owner] || (r_beat_cnt == c_last_beat)) begin
                        w_state_nxt = ST_IDLE;
                        w_gv_nxt    = 1'b0;
                        w_rr_nxt    = f_wrap_inc(r_owner);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_beat_cnt  <= '0;
            r_wr_en     <= 1'b0;
            r_din       <= '0;
            r_gnt_valid <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_owner     <= w_owner_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_wr_en     <= w_wr_nxt;
            r_din       <= w_din_nxt;
            r_gnt_valid <= w_gv_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    assign req_ack     = w_ack;
    assign fifo_wr_en  = r_wr_en;
    assign fifo_din    = r_din;
    assign gnt_valid   = r_gnt_valid;
    assign gnt_id      = r_owner;
    assign burst_abort = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter: directed vector
//                table, hand-written corner sequences and randomized traffic
//                checked against a behavioural model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int BM    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      req_ack;
    logic [CW-1:0]     fifo_counter = '0;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              gnt_valid;
    logic [1:0]        gnt_id;
    logic              burst_abort;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .CNT_W     (CW),
        .BURST_MAX (BM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ack      (req_ack),
        .fifo_counter (fifo_counter),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .burst_abort  (burst_abort)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // ---------------- behavioural reference model ----------------
    bit         m_busy;
    int         m_owner, m_beats, m_rr;
    bit         m_wr, m_abort;
    logic [7:0] m_din;
    int         acc_q[$];

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_beats = 0; m_rr = 0;
        m_wr = 0; m_abort = 0; m_din = '0;
    endtask

    function automatic logic [N-1:0] m_ack(input logic [N-1:0] r, input int cnt);
        int j;
        if (cnt + int'(m_wr) >= DEPTH) return '0;
        if (m_busy) return r[m_owner] ? N'(1 << m_owner) : '0;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (r[j]) return N'(1 << j);
        end
        return '0;
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                              input logic [N-1:0] l, input int cnt);
        logic [N-1:0] a;
        int  j;
        bit  drop;
        a    = m_ack(r, cnt);
        drop = m_busy && !r[m_owner];
        m_abort = drop;
        m_wr    = (a != '0);
        if (a != '0) begin
            j = 0;
            for (int k = 0; k < N; k++) if (a[k]) j = k;
            acc_q.push_back(j);
            m_din = d[j*DW +: DW];
            if (!m_busy) begin
                m_owner = j;
                m_beats = 1;
                if (l[j] || BM == 1) m_rr = (j + 1) % N;
                else m_busy = 1;
            end else begin
                m_beats++;
                if (l[j] || m_beats == BM) begin
                    m_busy = 0;
                    m_rr   = (j + 1) % N;
                end
            end
        end else if (drop) begin
            m_busy = 0;
            m_rr   = (m_owner + 1) % N;
        end
    endtask

    // Samples of the DUT taken mid-cycle by run_cycle.
    logic [N-1:0] s_ack;
    logic         s_wr, s_abort, s_gv;

    // Called at a rising edge; drives one cycle, checks against the model,
    // returns at the next rising edge with the model advanced.
    task automatic run_cycle(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                             input logic [N-1:0] l, input int cnt);
        #1;
        req = r; req_data = d; req_last = l; fifo_counter = CW'(cnt);
        #2;
        s_ack = req_ack; s_wr = fifo_wr_en; s_abort = burst_abort; s_gv = gnt_valid;
        chk("m_req_ack",     req_ack,     m_ack(r, cnt));
        chk("m_fifo_wr_en",  fifo_wr_en,  m_wr);
        chk("m_fifo_din",    fifo_din,    m_din);
        chk("m_gnt_valid",   gnt_valid,   m_busy);
        chk("m_gnt_id",      gnt_id,      m_owner);
        chk("m_burst_abort", burst_abort, m_abort);
        @(posedge clk);
        model_edge(r, d, l, cnt);
    endtask

    task automatic do_reset();
        req = '0; req_data = '0; req_last = '0; fifo_counter = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din",   fifo_din,   0);
        chk("rst_gv",    gnt_valid,  0);
        chk("rst_gid",   gnt_id,     0);
        chk("rst_abort", burst_abort, 0);
        chk("rst_ack",   req_ack,    0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    last;
        logic [N*DW-1:0] data;
        int              cnt;
        logic [N-1:0]    ack;   // combinational accept this cycle
        logic            wr;    // registered outputs visible this cycle
        logic [7:0]      din;
        logic            gv;
        int              gid;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [N-1:0] r, l;
        logic [N*DW-1:0] d;
        int fcnt;
        bit pop;

        // Single burst from requester 2, then wrap from rr_ptr=3, then a
        // streaming burst from requester 0 against a nearly full FIFO.
        tbl[0]  = '{4'b0100, 4'b0000, pk(8'h00, 8'h00, 8'h11, 8'h00), 0, 4'b0100, 1'b0, 8'h00, 1'b0, 0};
        tbl[1]  = '{4'b0100, 4'b0000, pk(8'h00, 8'h00, 8'h22, 8'h00), 0, 4'b0100, 1'b1, 8'h11, 1'b1, 2};
        tbl[2]  = '{4'b0100, 4'b0100, pk(8'h00, 8'h00, 8'h33, 8'h00), 0, 4'b0100, 1'b1, 8'h22, 1'b1, 2};
        tbl[3]  = '{4'b1001, 4'b1001, pk(8'hA0, 8'h00, 8'h00, 8'hD3), 0, 4'b1000, 1'b1, 8'h33, 1'b0, 2};
        tbl[4]  = '{4'b1001, 4'b1001, pk(8'hA0, 8'h00, 8'h00, 8'hD3), 0, 4'b0001, 1'b1, 8'hD3, 1'b0, 3};
        tbl[5]  = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 0, 4'b0000, 1'b1, 8'hA0, 1'b0, 0};
        tbl[6]  = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 0, 4'b0000, 1'b0, 8'hA0, 1'b0, 0};
        tbl[7]  = '{4'b0001, 4'b0000, pk(8'hA1, 8'h00, 8'h00, 8'h00), 7, 4'b0001, 1'b0, 8'hA0, 1'b0, 0};
        tbl[8]  = '{4'b0001, 4'b0000, pk(8'hA1, 8'h00, 8'h00, 8'h00), 7, 4'b0000, 1'b1, 8'hA1, 1'b1, 0};
        tbl[9]  = '{4'b0001, 4'b0000, pk(8'hA1, 8'h00, 8'h00, 8'h00), 8, 4'b0000, 1'b0, 8'hA1, 1'b1, 0};
        tbl[10] = '{4'b0001, 4'b0000, pk(8'hA2, 8'h00, 8'h00, 8'h00), 7, 4'b0001, 1'b0, 8'hA1, 1'b1, 0};
        tbl[11] = '{4'b0001, 4'b0001, pk(8'hA3, 8'h00, 8'h00, 8'h00), 8, 4'b0000, 1'b1, 8'hA2, 1'b1, 0};
        tbl[12] = '{4'b0001, 4'b0001, pk(8'hA3, 8'h00, 8'h00, 8'h00), 7, 4'b0001, 1'b0, 8'hA2, 1'b1, 0};
        tbl[13] = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 0, 4'b0000, 1'b1, 8'hA3, 1'b0, 0};

        do_reset();

        for (int i = 0; i < 14; i++) begin
            #1;
            req = tbl[i].req; req_last = tbl[i].last; req_data = tbl[i].data;
            fifo_counter = CW'(tbl[i].cnt);
            #2;
            chk($sformatf("tbl%0d_ack", i),   req_ack,     tbl[i].ack);
            chk($sformatf("tbl%0d_wr", i),    fifo_wr_en,  tbl[i].wr);
            chk($sformatf("tbl%0d_din", i),   fifo_din,    tbl[i].din);
            chk($sformatf("tbl%0d_gv", i),    gnt_valid,   tbl[i].gv);
            chk($sformatf("tbl%0d_gid", i),   gnt_id,      tbl[i].gid);
            chk($sformatf("tbl%0d_abort", i), burst_abort, 0);
            @(posedge clk);
        end

        // Abort: requester 1 drops req after two beats without last.
        do_reset();
        d = pk(8'h10, 8'h11, 8'h12, 8'h13);
        run_cycle(4'b0010, d, 4'b0000, 0);
        run_cycle(4'b0010, d, 4'b0000, 0);
        run_cycle(4'b1101, d, 4'b0000, 0);
        run_cycle(4'b1111, d, 4'b0000, 0);
        chk("abort_pulse",    s_abort, 1);
        chk("abort_gv_low",   s_gv,    0);
        chk("abort_next_gnt", s_ack,   4'b0100);
        run_cycle(4'b1111, d, 4'b0000, 0);
        chk("abort_one_cycle", s_abort, 0);

        // Fairness: everyone always requesting, no last; bursts cut at BM.
        do_reset();
        acc_q.delete();
        repeat (22) run_cycle(4'b1111, d, 4'b0000, 0);
        chk("fair_beats", (acc_q.size() >= 20), 1);
        for (int n = 0; n < 20 && n < acc_q.size(); n++) begin
            chk($sformatf("fair_owner%0d", n), acc_q[n], (n / BM) % N);
        end

        // Reset asserted during beat 2 of requester 1.
        do_reset();
        run_cycle(4'b0010, d, 4'b0000, 0);
        #1;
        req = 4'b0010;
        #1;
        chk("prerst_wr_en", fifo_wr_en, 1);
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", fifo_wr_en, 0);
        chk("midrst_gv",    gnt_valid,  0);
        chk("midrst_gid",   gnt_id,     0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req = 4'b1111;
        #2;
        chk("postrst_prio", req_ack, 4'b0001);
        @(posedge clk);

        // Randomized traffic against the model with a FIFO occupancy model.
        do_reset();
        fcnt = 0;
        for (int c = 0; c < 500; c++) begin
            r = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r = r | N'(1 << m_owner);
            l = '0;
            for (int k = 0; k < N; k++) l[k] = ($urandom_range(0, 3) == 0);
            d = {$urandom};
            pop = (fcnt > 0) && ($urandom_range(0, 2) == 0);
            run_cycle(r, d, l, fcnt);
            fcnt = fcnt + int'(s_wr) - int'(pop);
            chk("fifo_no_overflow", (fcnt <= DEPTH), 1);
            if (fcnt > DEPTH) fcnt = DEPTH;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
